// File: rtl/cpu_trace_buffer_if.sv
// Bus bundle for the execution-trace capture unit: control, CPU snoop inputs,
// readback index and the capture status/readback outputs.
// Handshake: there is no backpressure. sample_i is a plain per-cycle
// qualifier (one retired instruction per high cycle) and every sample is
// consumed on the edge it is presented; arm_i/abort_i are single-cycle pulses.
interface cpu_trace_buffer_if #(
   parameter int PC_W   = 5,
   parameter int INS_W  = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = PC_W + INS_W + DATA_W + 2;

   logic               arm_i;
   logic               abort_i;
   logic               trig_en_i;
   logic [PC_W-1:0]    trig_pc_i;
   logic [PTR_W-1:0]   post_cnt_i;
   logic               sample_i;
   logic [PC_W-1:0]    pc_i;
   logic [INS_W-1:0]   ins_i;
   logic [DATA_W-1:0]  acc_i;
   logic [1:0]         sw_i;
   logic [PTR_W:0]     rd_idx_i;
   logic [ENTRY_W-1:0] rd_data_o;
   logic [1:0]         state_o;
   logic               done_o;
   logic [PTR_W:0]     count_o;
   logic [PTR_W-1:0]   trig_pos_o;
   logic               overflow_o;

   modport master (
      output arm_i, abort_i, trig_en_i, trig_pc_i, post_cnt_i,
      output sample_i, pc_i, ins_i, acc_i, sw_i, rd_idx_i,
      input  rd_data_o, state_o, done_o, count_o, trig_pos_o, overflow_o
   );

   modport slave (
      input  arm_i, abort_i, trig_en_i, trig_pc_i, post_cnt_i,
      input  sample_i, pc_i, ins_i, acc_i, sw_i, rd_idx_i,
      output rd_data_o, state_o, done_o, count_o, trig_pos_o, overflow_o
   );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture unit for the accumulator CPU. Records retired
// instruction state into a circular buffer with pre-trigger history, a
// PC-match (or first-sample) trigger and a programmable post-trigger count.
// Entries are read back oldest-first through a registered read port.
module cpu_trace_buffer #(
   parameter int PC_W   = 5,
   parameter int INS_W  = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input logic              clk_i,
   input logic              reset,
   cpu_trace_buffer_if.slave bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = PC_W + INS_W + DATA_W + 2;
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W:0]     count;
   logic [PTR_W-1:0]   trig_pos;
   logic [PTR_W-1:0]   post_lat;
   logic [PTR_W-1:0]   remaining;
   logic               overflow;
   logic [ENTRY_W-1:0] rd_data;

   logic [ENTRY_W-1:0] mem [DEPTH];

   logic               capturing;
   logic               wr_en;
   logic               trig_hit;
   logic [ENTRY_W-1:0] wr_entry;
   logic [PTR_W:0]     rd_sum;
   logic [PTR_W-1:0]   rd_addr;
   logic               rd_valid;

   // Write qualification: arm/abort take the cycle, so a coincident sample is dropped.
   always_comb begin
      capturing = (state == ST_ARMED) || (state == ST_TRIGGERED);
      wr_en     = capturing && bus.sample_i && !bus.abort_i && !bus.arm_i;
      trig_hit  = bus.trig_en_i ? (bus.pc_i == bus.trig_pc_i) : 1'b1;
      wr_entry  = {bus.pc_i, bus.ins_i, bus.acc_i, bus.sw_i};
      // Oldest valid entry sits count slots behind the write pointer.
      rd_sum    = {1'b0, wr_ptr} - count + bus.rd_idx_i;
      rd_addr   = rd_sum[PTR_W-1:0];
      rd_valid  = bus.rd_idx_i < count;
   end

   // Capture FSM: arming, pointer/count bookkeeping, trigger and post-trigger countdown.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         count     <= '0;
         trig_pos  <= '0;
         post_lat  <= '0;
         remaining <= '0;
         overflow  <= 1'b0;
      end else if (bus.abort_i) begin
         // Buffer, count, trigger position and overflow are kept for readback.
         state <= ST_IDLE;
      end else if (bus.arm_i) begin
         state    <= ST_ARMED;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         post_lat <= bus.post_cnt_i;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (count == CNT_FULL) begin
            overflow <= 1'b1;
         end else begin
            count <= count + 1'b1;
         end
         if (state == ST_ARMED) begin
            if (trig_hit) begin
               trig_pos <= wr_ptr;
               if (post_lat == '0) begin
                  state <= ST_DONE;
               end else begin
                  remaining <= post_lat;
                  state     <= ST_TRIGGERED;
               end
            end
         end else begin
            remaining <= remaining - 1'b1;
            if (remaining == PTR_W'(1)) begin
               state <= ST_DONE;
            end
         end
      end
   end

   // Trace RAM write port; contents deliberately survive reset and abort.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Registered readback; reads the pre-write contents on an address collision.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_valid ? mem[rd_addr] : '0;
      end
   end

   assign bus.rd_data_o  = rd_data;
   assign bus.state_o    = state;
   assign bus.done_o     = (state == ST_DONE);
   assign bus.count_o    = count;
   assign bus.trig_pos_o = trig_pos;
   assign bus.overflow_o = overflow;
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised execution-trace capture unit for the accumulator CPU. It snoops per-instruction CPU state: PC, instruction, ACC, and the C/Z flags of SW. It records that state into a circular buffer, with pre-trigger history, a PC-match trigger and a programmable post-trigger sample count. After capture, the buffer is read back in chronological order. It sits beside the `cpu` core, driven from its debug outputs, and replaces cycle-limited bench printing with synthesizable capture.

Parameters:
PC_W, 5, PC width
INS_W, 8, instruction width
DATA_W, 8, ACC width
DEPTH, 8, buffer entries; power of 2, >= 2
(derived) PTR_W = $clog2(DEPTH); ENTRY_W = PC_W+INS_W+DATA_W+2

Ports:
clk_i  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
arm_i  in  1  pulse: start new capture
abort_i  in  1  pulse: stop capture, go IDLE
trig_en_i  in  1  1 = trigger on PC match; 0 = trigger on first sample
trig_pc_i  in  PC_W  trigger PC value
post_cnt_i  in  PTR_W  samples stored after the trigger sample; latched at arm
sample_i  in  1  CPU state valid this cycle (one instruction retired)
pc_i  in  PC_W  current PC
ins_i  in  INS_W  current instruction
acc_i  in  DATA_W  accumulator
sw_i  in  2  flags {C,Z}
rd_idx_i  in  PTR_W+1  readback index; 0 = oldest valid entry
rd_data_o  out  ENTRY_W  readback entry {pc,ins,acc,C,Z}, MSB first
state_o  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
done_o  out  1  state == DONE
count_o  out  PTR_W+1  valid entries, saturates at DEPTH
trig_pos_o  out  PTR_W  physical address of the trigger entry
overflow_o  out  1  sticky: pre-trigger history overwritten

Behaviour:
- Reset (reset=0, async):
  - state IDLE; wr_ptr, count_o, trig_pos_o and post counter 0.
  - overflow_o 0; rd_data_o 0.
  - Buffer RAM is not reset.
- IDLE: no writes. arm_i moves to ARMED next edge. On arm: wr_ptr=0, count=0, overflow=0, and post_cnt_i is latched.
- ARMED:
  - Each sample_i writes the entry at wr_ptr; wr_ptr increments mod DEPTH.
  - count increments, saturating at DEPTH.
  - A write while count==DEPTH sets overflow_o.
- Trigger:
  - Trigger condition: sample_i && (!trig_en_i || pc_i==trig_pc_i), evaluated in ARMED only.
  - The triggering sample is written normally and trig_pos_o is set to its address.
  - If the latched post count is 0, go to DONE; otherwise go to TRIGGERED with the remaining count set to the latched value.
- TRIGGERED:
  - Each sample_i writes (same pointer/count rules) and decrements the remaining count.
  - The write that brings remaining to 0 moves the state to DONE on the same edge.
  - post_cnt_i max is DEPTH-1, so the trigger entry is never overwritten.
- DONE: no writes; done_o=1; samples are ignored. arm_i re-arms as from IDLE.
- abort_i: in any state goes to IDLE next edge, retaining buffer, count, trig_pos and overflow. abort_i has priority over arm_i in the same cycle.
- arm_i in ARMED/TRIGGERED: restarts the capture (same as arm from IDLE).
- Readback:
  - Physical address = (wr_ptr - count + rd_idx_i) mod DEPTH.
  - rd_data_o is registered: rd_idx_i applied in cycle n gives data in cycle n+1.
  - rd_idx_i >= count_o returns 0.
  - Readback is legal in every state.
  - A read and a write to the same address in one cycle returns the old content.
- All pointer arithmetic is modulo DEPTH; count is compared at PTR_W+1 bits.

Test Plan:
1. Reset mid-capture: while TRIGGERED with count=3, drive reset=0 between edges -> state_o=0, count_o=0 and rd_data_o=0 immediately (asynchronously); no writes until re-armed.
2. Immediate trigger: trig_en=0, post_cnt=2, arm, samples with PC 0..5 -> PC 0 triggers, trig_pos=0; entries PC 0,1,2 stored; DONE after PC 2; count=3; rd_idx=0 gives {pc=0,...}.
3. PC-match trigger: trig_en=1, trig_pc=5, post_cnt=1, PCs 0..12 consecutive -> count=7, trig_pos=5, oldest entry PC 0, newest PC 6, overflow=0, done_o=1.
4. Wrap/overflow: trig_pc=20 (PC_W=5), post_cnt=0, PCs 0..20 -> count=8, overflow=1, rd_idx 0..7 return PCs 13..20, rd_idx=8 returns 0.
5. Control priority: arm_i and abort_i in the same cycle while ARMED -> IDLE, buffer retained. A later arm clears count and overflow.
6. Readback latency and gapped sampling: sample_i low on alternate cycles -> only strobed samples stored. rd_idx changed at cycle n updates rd_data_o at n+1, stable otherwise.
